// File: rtl/bus_pkg.sv
// Shared definitions for the two-master split-capable bus arbiter.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
// Contents: arbiter state encoding, master IDs and default ack-timeout sizing.
package bus_pkg;

   // Arbiter ownership states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2
   } arb_state_t;

   // Master identifiers.
   localparam logic M1 = 1'b0;
   localparam logic M2 = 1'b1;

   // Default cycles allowed from grant to ack, and a timer wide enough to hold it.
   localparam int DEFAULT_ACK_TIMEOUT = 16;
   localparam int DEFAULT_CNT_WIDTH   = 5;

   // The master that is not 'id'; used for round-robin tie breaking.
   function automatic logic other_id(input logic id);
      return ~id;
   endfunction

   // Grant state that corresponds to a master ID.
   function automatic arb_state_t gnt_state(input logic id);
      return (id == M2) ? GNT2 : GNT1;
   endfunction

endpackage

// File: rtl/arb_ack_timer.sv
// Ack watchdog counter: counts grant cycles and flags the terminal count.
// Latency: count advances one per enabled cycle; tc is combinational from the count.
// Backpressure: none; en simply freezes the count.
// Ports: clk, rst (sync, active-high), clr (force count to zero), en (advance), tc (count == ACK_TIMEOUT-1).
module arb_ack_timer
   import bus_pkg::*;
#(
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(ACK_TIMEOUT - 1);

   logic [CNT_WIDTH-1:0] cnt;

   // Saturates at the terminal value so a stalled owner cannot wrap the
   // counter back to zero and dodge the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != TC_VAL)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/bus_arbiter_split.sv
// Two-master round-robin bus arbiter with one outstanding split transaction.
// Latency: grant, msel and all pulses are registered; a request sampled in IDLE is granted the next cycle.
// Backpressure: masters hold breq until released; a split master is parked until split_done, then resumed first.
// Ports: clk, rst (sync, active-high); breq1/breq2 requests; ack/ssplit from decoder and slave;
//        split_done from the split slave; bgrant1/bgrant2/msel to the master mux;
//        split_grant/split_err/timeout one-cycle pulses.
module bus_arbiter_split
   import bus_pkg::*;
#(
   parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic breq1,
   input  logic breq2,
   input  logic ack,
   input  logic ssplit,
   input  logic split_done,
   output logic bgrant1,
   output logic bgrant2,
   output logic msel,
   output logic split_grant,
   output logic split_err,
   output logic timeout
);

   arb_state_t state;
   logic       split_pend;
   logic       split_id;
   logic       last_id;
   logic       acked;

   logic       in_gnt;
   logic       owner_id;
   logic       owner_req;
   logic       elig1;
   logic       elig2;
   logic       resume;
   logic       pick_vld;
   logic       pick_id;
   logic       timer_tc;
   logic       timer_en;
   logic       timeout_hit;

   assign in_gnt    = (state == GNT1) || (state == GNT2);
   assign owner_id  = (state == GNT2) ? M2 : M1;
   assign owner_req = (owner_id == M2) ? breq2 : breq1;

   // A parked split master is not eligible even with breq held high, so it
   // cannot starve the other master while its slave is busy.
   assign elig1  = breq1 && !(split_pend && (split_id == M1));
   assign elig2  = breq2 && !(split_pend && (split_id == M2));
   assign resume = split_pend && split_done;

   // Selection in IDLE: split resume first, then round-robin among eligibles.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = M1;
      if (resume) begin
         pick_vld = 1'b1;
         pick_id  = split_id;
      end else if (elig1 && elig2) begin
         pick_vld = 1'b1;
         pick_id  = other_id(last_id);
      end else if (elig1) begin
         pick_vld = 1'b1;
         pick_id  = M1;
      end else if (elig2) begin
         pick_vld = 1'b1;
         pick_id  = M2;
      end
   end

   // Every tenure is preceded by at least one IDLE cycle, so holding the
   // timer clear in IDLE restarts it from zero on each grant. It stops once
   // ack has been seen; an ack in the terminal cycle still wins.
   assign timer_en    = in_gnt && !acked && !ack;
   assign timeout_hit = in_gnt && !acked && !ack && timer_tc;

   arb_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_ack_timer (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE),
      .en  (timer_en),
      .tc  (timer_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         split_pend  <= 1'b0;
         split_id    <= M1;
         last_id     <= M2;      // master 1 wins the first tie
         acked       <= 1'b0;
         bgrant1     <= 1'b0;
         bgrant2     <= 1'b0;
         msel        <= 1'b0;
         split_grant <= 1'b0;
         split_err   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         split_grant <= 1'b0;
         split_err   <= 1'b0;
         timeout     <= 1'b0;

         case (state)
            IDLE: begin
               acked <= 1'b0;
               if (pick_vld) begin
                  state   <= gnt_state(pick_id);
                  bgrant1 <= (pick_id == M1);
                  bgrant2 <= (pick_id == M2);
                  msel    <= pick_id;
                  if (resume) begin
                     split_grant <= 1'b1;
                     split_pend  <= 1'b0;
                  end
               end
            end

            GNT1, GNT2: begin
               if (ack) begin
                  acked <= 1'b1;
               end
               // ssplit outranks a simultaneous breq fall so the split is kept.
               if (ssplit || !owner_req || timeout_hit) begin
                  state   <= IDLE;
                  bgrant1 <= 1'b0;
                  bgrant2 <= 1'b0;
                  last_id <= owner_id;
                  if (ssplit) begin
                     if (!split_pend) begin
                        split_pend <= 1'b1;
                        split_id   <= owner_id;
                     end else begin
                        // Only one split can be outstanding; this one is
                        // reported and otherwise handled as a release.
                        split_err <= 1'b1;
                     end
                  end else if (owner_req) begin
                     timeout <= 1'b1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               bgrant1 <= 1'b0;
               bgrant2 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_split.sv
module tb_bus_arbiter_split;

   localparam int ACK_TO = 16;

   logic clk = 1'b0;
   logic rst, breq1, breq2, ack, ssplit, split_done;
   logic bgrant1, bgrant2, msel, split_grant, split_err, timeout;

   int errors = 0;
   int checks = 0;

   // Reference model state, expressed in terms of who owns the bus.
   int m_owner;      // 0 = nobody, 1 or 2 = master number
   bit m_pend;
   int m_pend_id;    // parked master number
   int m_last;       // last master to finish a tenure
   int m_age;        // grant cycles elapsed without ack
   bit m_acked;
   logic e_g1, e_g2, e_ms, e_sg, e_se, e_to;

   bus_arbiter_split #(.ACK_TIMEOUT(ACK_TO), .CNT_WIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .breq1       (breq1),
      .breq2       (breq2),
      .ack         (ack),
      .ssplit      (ssplit),
      .split_done  (split_done),
      .bgrant1     (bgrant1),
      .bgrant2     (bgrant2),
      .msel        (msel),
      .split_grant (split_grant),
      .split_err   (split_err),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit c1, c2, req, ends;
      e_sg = 1'b0; e_se = 1'b0; e_to = 1'b0;
      if (rst) begin
         m_owner = 0; m_pend = 0; m_pend_id = 1; m_last = 2;
         m_age = 0; m_acked = 0; e_ms = 1'b0;
      end else if (m_owner == 0) begin
         if (m_pend && split_done) begin
            m_owner = m_pend_id;
            m_pend  = 0;
            e_sg    = 1'b1;
         end else begin
            c1 = breq1 && !(m_pend && m_pend_id == 1);
            c2 = breq2 && !(m_pend && m_pend_id == 2);
            if (c1 && c2)  m_owner = (m_last == 1) ? 2 : 1;
            else if (c1)   m_owner = 1;
            else if (c2)   m_owner = 2;
         end
         if (m_owner != 0) begin
            m_age = 0; m_acked = 0;
            e_ms = (m_owner == 2);
         end
      end else begin
         req  = (m_owner == 1) ? breq1 : breq2;
         ends = 0;
         if (ssplit) begin
            ends = 1;
            if (!m_pend) begin m_pend = 1; m_pend_id = m_owner; end
            else e_se = 1'b1;
         end else if (!req) begin
            ends = 1;
         end else if (!m_acked && !ack && m_age == ACK_TO - 1) begin
            ends = 1;
            e_to = 1'b1;
         end
         if (ack) m_acked = 1;
         else if (!m_acked) m_age++;
         if (ends) begin
            m_last  = m_owner;
            m_owner = 0;
         end
      end
      e_g1 = (m_owner == 1);
      e_g2 = (m_owner == 2);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("bgrant1", bgrant1, e_g1);
      chk("bgrant2", bgrant2, e_g2);
      chk("msel", msel, e_ms);
      chk("split_grant", split_grant, e_sg);
      chk("split_err", split_err, e_se);
      chk("timeout", timeout, e_to);
   endtask

   task automatic set_in(input logic b1, input logic b2, input logic a,
                         input logic ss, input logic sd);
      breq1 = b1; breq2 = b2; ack = a; ssplit = ss; split_done = sd;
   endtask

   initial begin
      int n;
      bit seen;
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      e_ms = 1'b0;
      step();
      step();
      chk("rst_g1", bgrant1, 1'b0);
      chk("rst_msel", msel, 1'b0);

      // Both request after reset: master 1 first, then master 2 after a turnaround.
      rst = 1'b0;
      set_in(1, 1, 0, 0, 0);
      step();
      chk("tie_g1", bgrant1, 1'b1);
      chk("tie_msel", msel, 1'b0);
      set_in(1, 1, 1, 0, 0); step();
      set_in(1, 1, 0, 0, 0); step();
      set_in(0, 1, 0, 0, 0); step();
      chk("turn_g1", bgrant1, 1'b0);
      chk("turn_g2", bgrant2, 1'b0);
      step();
      chk("rr_g2", bgrant2, 1'b1);
      chk("rr_msel", msel, 1'b1);
      set_in(0, 0, 0, 0, 0); step(); step();

      // Master 1 acks then splits; master 2 proceeds while master 1 stays parked.
      set_in(1, 0, 0, 0, 0); step();
      repeat (3) step();
      set_in(1, 0, 1, 0, 0); step();
      set_in(1, 0, 0, 0, 0); repeat (2) step();
      set_in(1, 0, 0, 1, 0); step();
      chk("split_drop_g1", bgrant1, 1'b0);
      set_in(1, 1, 0, 0, 0); step();
      chk("parked_other_g2", bgrant2, 1'b1);
      set_in(1, 0, 0, 0, 0); step();
      repeat (3) begin
         step();
         chk("parked_ignored", bgrant1, 1'b0);
      end

      // Resume beats a tie in IDLE.
      set_in(1, 1, 0, 0, 1); step();
      chk("resume_g1", bgrant1, 1'b1);
      chk("resume_pulse", split_grant, 1'b1);
      set_in(1, 1, 0, 0, 0); step();
      chk("resume_pulse_end", split_grant, 1'b0);

      // Master 2 never acks: timeout exactly ACK_TO cycles after grant.
      set_in(0, 1, 0, 0, 0); step();
      step();
      chk("to_g2", bgrant2, 1'b1);
      set_in(1, 1, 0, 0, 0);
      n = 0; seen = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         step();
         if (timeout === 1'b1) begin seen = 1; n = i; end
      end
      chk_int("to_latency", n, ACK_TO);
      chk("to_drop_g2", bgrant2, 1'b0);
      step();
      chk("to_next_g1", bgrant1, 1'b1);

      // Master 1 splits, then master 2 splits too: split_err, split_id stays M1.
      set_in(1, 1, 0, 1, 0); step();
      set_in(1, 1, 0, 0, 0); step();
      chk("err_pre_g2", bgrant2, 1'b1);
      set_in(1, 1, 0, 1, 0); step();
      chk("err_pulse", split_err, 1'b1);
      chk("err_drop_g2", bgrant2, 1'b0);
      set_in(1, 0, 0, 0, 1); step();
      chk("err_resume_g1", bgrant1, 1'b1);

      // Reset mid-grant while master 2 is parked: the split is forgotten.
      set_in(0, 1, 0, 0, 0); step(); step();
      set_in(1, 1, 0, 1, 0); step();
      set_in(1, 1, 0, 0, 0); step();
      chk("pre_rst_g1", bgrant1, 1'b1);
      rst = 1'b1; step();
      chk("rst_mid_g1", bgrant1, 1'b0);
      chk("rst_mid_msel", msel, 1'b0);
      rst = 1'b0;
      set_in(0, 1, 0, 0, 0); step();
      chk("post_rst_g2", bgrant2, 1'b1);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) breq1 = ~breq1;
         if ($urandom_range(0, 7) == 0) breq2 = ~breq2;
         ack        = ($urandom_range(0, 9) == 0);
         ssplit     = ($urandom_range(0, 15) == 0);
         split_done = ($urandom_range(0, 5) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
